// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Types and constants shared by the ALU operation sequencer and its register
// file: the ALU select encoding, the sequencer state encoding and the ALU
// datapath width.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_WIDTH = 16;

   typedef enum logic [1:0] {
      ALU_PASS = 2'b00,
      ALU_ADD  = 2'b01,
      ALU_SUB  = 2'b10,
      ALU_CLR  = 2'b11
   } alu_sel_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_DONE = 2'b10
   } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// NUM_REGS x WIDTH register file with two asynchronous read ports and two
// write ports. The write-back port has priority over the direct load port
// when both target the same register on the same edge.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears all regs)
//   rd_addr_a/rd_data_a read port A (combinational)
//   rd_addr_b/rd_data_b read port B (combinational)
//   ld_en/ld_addr/ld_data  direct load write port
//   wb_en/wb_addr/wb_data  ALU write-back port (wins on collision)
// -----------------------------------------------------------------------------
module alu_regfile
   import alu_pkg::*;
#(
   parameter int WIDTH    = ALU_WIDTH,
   parameter int NUM_REGS = 4,
   parameter int REG_AW   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rd_addr_a,
   output logic [WIDTH-1:0]  rd_data_a,
   input  logic [REG_AW-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_b,
   input  logic              ld_en,
   input  logic [REG_AW-1:0] ld_addr,
   input  logic [WIDTH-1:0]  ld_data,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [WIDTH-1:0]  wb_data
);

   logic [WIDTH-1:0] mem [NUM_REGS];

   assign rd_data_a = mem[rd_addr_a];
   assign rd_data_b = mem[rd_addr_b];

   // Register storage: write-back checked first so it overrides a same-edge load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= {WIDTH{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wb_en && (wb_addr == REG_AW'(i))) begin
               mem[i] <= wb_data;
            end else if (ld_en && (ld_addr == REG_AW'(i))) begin
               mem[i] <= ld_data;
            end else begin
               mem[i] <= mem[i];
            end
         end
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Accepts one ALU instruction per valid/ready handshake, reads both operands
// from the local register file, drives the external ALU inputs, and writes
// the ALU result back to the destination register one cycle later.
// Sequence: IDLE (accept) -> EXEC (write-back) -> DONE (done pulse) -> IDLE.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   instr_valid/instr_ready   instruction handshake (ready only in IDLE)
//   instr_op/rd/rs1/rs2       operation and register addresses
//   load_en/addr/data         direct register write, any state
//   alu_a/alu_b/alu_sel       registered drive to the ALU
//   alu_result                combinational ALU output
//   done/done_rd/done_data    one-cycle write-back report
// -----------------------------------------------------------------------------
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH    = ALU_WIDTH,
   parameter int NUM_REGS = 4,
   parameter int REG_AW   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [1:0]        instr_op,
   input  logic [REG_AW-1:0] instr_rd,
   input  logic [REG_AW-1:0] instr_rs1,
   input  logic [REG_AW-1:0] instr_rs2,
   input  logic              load_en,
   input  logic [REG_AW-1:0] load_addr,
   input  logic [WIDTH-1:0]  load_data,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [1:0]        alu_sel,
   input  logic [WIDTH-1:0]  alu_result,
   output logic              done,
   output logic [REG_AW-1:0] done_rd,
   output logic [WIDTH-1:0]  done_data
);

   seq_state_t        state_r;
   seq_state_t        next_state_s;
   logic [REG_AW-1:0] rd_r;
   logic [WIDTH-1:0]  rs1_data_s;
   logic [WIDTH-1:0]  rs2_data_s;
   logic              accept_s;
   logic              wb_en_s;

   assign accept_s = (state_r == S_IDLE) && instr_valid;
   assign wb_en_s  = (state_r == S_EXEC);

   alu_regfile #(
      .WIDTH    (WIDTH),
      .NUM_REGS (NUM_REGS),
      .REG_AW   (REG_AW)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (instr_rs1),
      .rd_data_a (rs1_data_s),
      .rd_addr_b (instr_rs2),
      .rd_data_b (rs2_data_s),
      .ld_en     (load_en),
      .ld_addr   (load_addr),
      .ld_data   (load_data),
      .wb_en     (wb_en_s),
      .wb_addr   (rd_r),
      .wb_data   (alu_result)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (instr_valid) begin
               next_state_s = S_EXEC;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_EXEC:  next_state_s = S_DONE;
         S_DONE:  next_state_s = S_IDLE;
         default: next_state_s = S_IDLE;
      endcase
   end

   // FSM output decode: only IDLE can take an instruction
   always_comb begin
      instr_ready = 1'b0;
      case (state_r)
         S_IDLE:  instr_ready = 1'b1;
         S_EXEC:  instr_ready = 1'b0;
         S_DONE:  instr_ready = 1'b0;
         default: instr_ready = 1'b0;
      endcase
   end

   // Operand/select capture at accept; values hold until the next accept so
   // a load to a source register during EXEC cannot disturb the in-flight op
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a   <= {WIDTH{1'b0}};
         alu_b   <= {WIDTH{1'b0}};
         alu_sel <= ALU_PASS;
         rd_r    <= {REG_AW{1'b0}};
      end else if (accept_s) begin
         alu_a   <= rs1_data_s;
         alu_b   <= rs2_data_s;
         alu_sel <= instr_op;
         rd_r    <= instr_rd;
      end else begin
         alu_a   <= alu_a;
         alu_b   <= alu_b;
         alu_sel <= alu_sel;
         rd_r    <= rd_r;
      end
   end

   // Completion report: done is high only in the cycle after the write-back edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done      <= 1'b0;
         done_rd   <= {REG_AW{1'b0}};
         done_data <= {WIDTH{1'b0}};
      end else if (wb_en_s) begin
         done      <= 1'b1;
         done_rd   <= rd_r;
         done_data <= alu_result;
      end else begin
         done      <= 1'b0;
         done_rd   <= done_rd;
         done_data <= done_data;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Bench for alu_op_sequencer plus a behavioural 16-bit ALU. Expected write-back
// values come from a reference register model and are queued when an
// instruction is issued; they are popped when done pulses.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [1:0]  instr_op;
   logic [1:0]  instr_rd;
   logic [1:0]  instr_rs1;
   logic [1:0]  instr_rs2;
   logic        load_en;
   logic [1:0]  load_addr;
   logic [15:0] load_data;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [1:0]  alu_sel;
   logic [15:0] alu_result;
   logic        done;
   logic [1:0]  done_rd;
   logic [15:0] done_data;

   typedef struct packed {
      logic [1:0]  rd;
      logic [15:0] data;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] ref_regs [4];
   int          checks;
   int          errors;
   int          done_count;

   alu_op_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_op    (instr_op),
      .instr_rd    (instr_rd),
      .instr_rs1   (instr_rs1),
      .instr_rs2   (instr_rs2),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_sel     (alu_sel),
      .alu_result  (alu_result),
      .done        (done),
      .done_rd     (done_rd),
      .done_data   (done_data)
   );

   // Behavioural combinational ALU
   always_comb begin
      case (alu_sel)
         2'b00:   alu_result = alu_a;
         2'b01:   alu_result = alu_a + alu_b;
         2'b10:   alu_result = alu_a - alu_b;
         2'b11:   alu_result = 16'h0000;
         default: alu_result = 16'h0000;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop and compare on each done pulse
   always @(negedge clk) begin
      if (!rst && done) begin
         exp_t e;
         done_count++;
         chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("done_rd", {30'd0, done_rd}, {30'd0, e.rd});
            chk("done_data", {16'd0, done_data}, {16'd0, e.data});
         end
      end
   end

   // Tasks start and end just after a falling edge
   task automatic do_load(input logic [1:0] a, input logic [15:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge clk);
      load_en = 1'b0;
      ref_regs[a] = d;
   endtask

   task automatic issue(input logic [1:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2,
                        input logic exec_ld, input logic [1:0] ld_a,
                        input logic [15:0] ld_d);
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      a = ref_regs[rs1];
      b = ref_regs[rs2];
      case (op)
         2'b00:   r = a;
         2'b01:   r = a + b;
         2'b10:   r = a - b;
         default: r = 16'h0000;
      endcase
      instr_valid = 1'b1;
      instr_op    = op;
      instr_rd    = rd;
      instr_rs1   = rs1;
      instr_rs2   = rs2;
      chk("ready_idle", {31'd0, instr_ready}, 32'd1);
      @(negedge clk);
      instr_valid = 1'b0;
      chk("exec_ready", {31'd0, instr_ready}, 32'd0);
      chk("exec_done", {31'd0, done}, 32'd0);
      chk("alu_a", {16'd0, alu_a}, {16'd0, a});
      chk("alu_b", {16'd0, alu_b}, {16'd0, b});
      chk("alu_sel", {30'd0, alu_sel}, {30'd0, op});
      if (exec_ld) begin
         load_en   = 1'b1;
         load_addr = ld_a;
         load_data = ld_d;
         ref_regs[ld_a] = ld_d;
      end
      sb_q.push_back('{rd: rd, data: r});
      ref_regs[rd] = r;
      @(negedge clk);
      load_en = 1'b0;
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("done_ready", {31'd0, instr_ready}, 32'd0);
      chk("reg_rd", {16'd0, dut.u_regfile.mem[rd]}, {16'd0, ref_regs[rd]});
      if (exec_ld) begin
         chk("reg_ld", {16'd0, dut.u_regfile.mem[ld_a]}, {16'd0, ref_regs[ld_a]});
      end
      @(negedge clk);
      chk("done_clear", {31'd0, done}, 32'd0);
      chk("ready_back", {31'd0, instr_ready}, 32'd1);
   endtask

   initial begin
      int dc0;
      checks      = 0;
      errors      = 0;
      done_count  = 0;
      rst         = 1'b1;
      instr_valid = 1'b0;
      instr_op    = 2'b00;
      instr_rd    = 2'b00;
      instr_rs1   = 2'b00;
      instr_rs2   = 2'b00;
      load_en     = 1'b0;
      load_addr   = 2'b00;
      load_data   = 16'h0000;
      for (int i = 0; i < 4; i++) ref_regs[i] = 16'h0000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_ready", {31'd0, instr_ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_alu_sel", {30'd0, alu_sel}, 32'd0);
      chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
      chk("rst_done_data", {16'd0, done_data}, 32'd0);
      for (int i = 0; i < 4; i++) chk("rst_reg", {16'd0, dut.u_regfile.mem[i]}, 32'd0);

      // Add
      do_load(2'd0, 16'h0003);
      do_load(2'd1, 16'h0004);
      issue(2'b01, 2'd2, 2'd0, 2'd1, 1'b0, 2'd0, 16'h0000);

      // Sub wrap, then add wrap
      do_load(2'd0, 16'h0000);
      do_load(2'd1, 16'h0001);
      issue(2'b10, 2'd3, 2'd0, 2'd1, 1'b0, 2'd0, 16'h0000);
      issue(2'b01, 2'd2, 2'd3, 2'd1, 1'b0, 2'd0, 16'h0000);

      // Pass of a non-zero value, rs1==rs2 add with rd==rs1
      issue(2'b00, 2'd0, 2'd3, 2'd1, 1'b0, 2'd0, 16'h0000);
      do_load(2'd2, 16'h4321);
      issue(2'b01, 2'd2, 2'd2, 2'd2, 1'b0, 2'd0, 16'h0000);

      // Clear / pass
      do_load(2'd1, 16'hBEEF);
      issue(2'b11, 2'd1, 2'd1, 2'd1, 1'b0, 2'd0, 16'h0000);
      issue(2'b00, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 16'h0000);

      // Collisions: write-back beats load; load to rs1 in EXEC does not disturb operands
      do_load(2'd0, 16'h0005);
      do_load(2'd1, 16'h0006);
      issue(2'b01, 2'd2, 2'd0, 2'd1, 1'b1, 2'd2, 16'h1234);
      issue(2'b01, 2'd3, 2'd0, 2'd1, 1'b1, 2'd0, 16'h0100);

      // Handshake: valid held for 9 cycles -> exactly 3 ops
      do_load(2'd2, 16'h0000);
      do_load(2'd3, 16'h0001);
      dc0 = done_count;
      sb_q.push_back('{rd: 2'd2, data: 16'h0001});
      sb_q.push_back('{rd: 2'd2, data: 16'h0002});
      sb_q.push_back('{rd: 2'd2, data: 16'h0003});
      ref_regs[2] = 16'h0003;
      instr_valid = 1'b1;
      instr_op    = 2'b01;
      instr_rd    = 2'd2;
      instr_rs1   = 2'd2;
      instr_rs2   = 2'd3;
      for (int k = 0; k < 9; k++) begin
         chk("hs_ready", {31'd0, instr_ready}, {31'd0, (k % 3) == 0});
         @(negedge clk);
      end
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("hs_done_count", done_count - dc0, 32'd3);
      chk("hs_reg", {16'd0, dut.u_regfile.mem[2]}, {16'd0, ref_regs[2]});

      // Reset during EXEC: op aborted, no done
      dc0 = done_count;
      instr_valid = 1'b1;
      instr_op    = 2'b01;
      instr_rd    = 2'd1;
      instr_rs1   = 2'd0;
      instr_rs2   = 2'd3;
      @(negedge clk);
      instr_valid = 1'b0;
      chk("pre_rst_exec", {31'd0, instr_ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_mid_done", {31'd0, done}, 32'd0);
      chk("rst_mid_sel", {30'd0, alu_sel}, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         ref_regs[i] = 16'h0000;
         chk("rst_mid_reg", {16'd0, dut.u_regfile.mem[i]}, 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rel_ready", {31'd0, instr_ready}, 32'd1);
      repeat (3) @(negedge clk);
      chk("rst_no_done", done_count - dc0, 32'd0);
      chk("sb_empty", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
